// File: rtl/pixel_capture_if.sv
// Stream, handshake and readout signals between a pixel source/consumer and pixel_capture.
// Signal names follow the pipeline's established Pixel/Frame/Line naming.
interface pixel_capture_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        Pixel;
  logic              Frame;
  logic              Line;
  logic              FrameReady;
  logic              FrameAck;
  logic [ADDR_W-1:0] RdAddr;
  logic [7:0]        RdData;
  logic              LineErr;
  logic              FrameErr;
  logic [7:0]        FrameCount;

  modport master (
    output Pixel, Frame, Line, FrameAck, RdAddr,
    input  FrameReady, RdData, LineErr, FrameErr, FrameCount
  );

  modport slave (
    input  Pixel, Frame, Line, FrameAck, RdAddr,
    output FrameReady, RdData, LineErr, FrameErr, FrameCount
  );
endinterface

// File: rtl/pixel_capture.sv
// Captures one WIDTH x HEIGHT frame from the raster pixel stream into a byte memory,
// checks line geometry, and holds the frame for random-access readout until acknowledged.
module pixel_capture #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int ADDR_W = 12
) (
  input logic             Clk,
  input logic             nReset,
  pixel_capture_if.slave  bus
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] wr_addr;

  logic [COL_W-1:0]  eff_col;
  logic [ROW_W-1:0]  eff_row;
  logic [ADDR_W-1:0] wa;
  logic              we;
  logic              line_bad;

  logic [7:0] mem [0:DEPTH-1];

  // A Frame pulse always means "this pixel is row 0, col 0", whatever the counters say.
  always_comb begin
    we       = 1'b0;
    eff_col  = bus.Frame ? '0 : col;
    eff_row  = bus.Frame ? '0 : row;
    wa       = bus.Frame ? '0 : wr_addr;
    line_bad = bus.Line != (eff_col == LAST_COL);
    case (state)
      IDLE:    we = bus.Frame;
      CAPTURE: we = 1'b1;
      DONE:    we = bus.FrameAck & bus.Frame;
      default: we = 1'b0;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      wr_addr        <= '0;
      bus.FrameReady <= 1'b0;
      bus.LineErr    <= 1'b0;
      bus.FrameErr   <= 1'b0;
      bus.FrameCount <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Frame) begin
            state   <= CAPTURE;
            col     <= COL_ONE;
            row     <= '0;
            wr_addr <= ADDR_ONE;
          end
        end

        CAPTURE: begin
          if (bus.Frame) bus.FrameErr <= 1'b1;
          if (line_bad) begin
            bus.LineErr <= 1'b1;
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            wr_addr     <= '0;
          end else if (bus.Line) begin
            col <= '0;
            if (eff_row == LAST_ROW) begin
              state          <= DONE;
              row            <= '0;
              wr_addr        <= '0;
              bus.FrameReady <= 1'b1;
              bus.FrameCount <= bus.FrameCount + 8'd1;
            end else begin
              row     <= eff_row + ROW_ONE;
              wr_addr <= wa + ADDR_ONE;
            end
          end else begin
            col     <= eff_col + COL_ONE;
            row     <= eff_row;
            wr_addr <= wa + ADDR_ONE;
          end
        end

        DONE: begin
          if (bus.FrameAck) begin
            bus.FrameReady <= 1'b0;
            bus.LineErr    <= 1'b0;
            bus.FrameErr   <= 1'b0;
            if (bus.Frame) begin
              state   <= CAPTURE;
              col     <= COL_ONE;
              row     <= '0;
              wr_addr <= ADDR_ONE;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the frame store has no reset; clearing a RAM needs a sweep and would stop it
  // mapping onto block memory. Its contents are meaningful only after a capture.
  always_ff @(posedge Clk) begin
    if (we) mem[wa] <= bus.Pixel;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) bus.RdData <= 8'd0;
    else         bus.RdData <= mem[bus.RdAddr];
  end

endmodule
